// File: rtl/apb_requester.sv
// APB requester: accepts one command at a time and runs it as an APB SETUP/ACCESS transfer.
// Optional ACCESS-phase timeout is compiled in with `define APB_REQ_TIMEOUT_EN.
module apb_requester #(
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned TIMEOUT    = 16,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  output logic [2:0]            pprot,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   complete;
  logic   abort;
  logic   tmo_hit;

`ifdef APB_REQ_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !pready) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // cmd_ready in ACCESS follows pready combinationally so a queued command chains with no idle gap.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          complete  = 1'b1;
          cmd_ready = 1'b1;
          state_nxt = cmd_valid ? SETUP : IDLE;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (preset) cmd_ready = 1'b0;
  end

  assign accept  = cmd_valid & cmd_ready;
  assign psel    = (state != IDLE);
  assign penable = (state == ACCESS);

  // Response uses the pwrite of the finishing transfer even when a new command is latched on the same edge.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
    end else begin
      rsp_valid <= complete | abort;
      if (complete) begin
        rsp_err   <= pslverr;
        rsp_rdata <= pwrite ? '0 : prdata;
      end else if (abort) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
      if (accept) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
        pstrb  <= cmd_write ? cmd_strb : '0;
        pprot  <= cmd_prot;
      end
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: table of single transfers plus chaining, reset and wait-limit sequences.
module tb_apb_requester;

  logic        pclk;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  apb_requester #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (4)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_write(cmd_write),
    .cmd_wdata(cmd_wdata),
    .cmd_strb (cmd_strb),
    .cmd_prot (cmd_prot),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .pprot    (pprot),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int unsigned waits;
    logic [31:0] rdata;
    logic        slverr;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
  endtask

  task automatic do_xfer(input vec_t v);
    @(negedge pclk);
    cmd_valid = 1'b1;
    drive_cmd(v.wr, v.addr, v.wdata, v.strb, v.prot);
    pready = 1'b0;
    #1;
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle_psel", 64'(psel), 64'd0);
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);

    @(negedge pclk);
    cmd_valid = 1'b0;
    drive_cmd(1'b0, 32'h5555_5555, 32'h6666_6666, 4'h0, 3'h0);
    #1;
    chk("setup_psel", 64'(psel), 64'd1);
    chk("setup_penable", 64'(penable), 64'd0);
    chk("setup_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("setup_paddr", 64'(paddr), 64'(v.addr));
    chk("setup_pwrite", 64'(pwrite), 64'(v.wr));
    chk("setup_pwdata", 64'(pwdata), 64'(v.wdata));
    chk("setup_pstrb", 64'(pstrb), 64'(v.exp_strb));
    chk("setup_pprot", 64'(pprot), 64'(v.prot));

    for (int unsigned w = 0; w < v.waits; w++) begin
      @(negedge pclk);
      pready  = 1'b0;
      prdata  = $urandom;
      pslverr = 1'($urandom_range(1, 0));
      #1;
      chk("wait_penable", 64'(penable), 64'd1);
      chk("wait_psel", 64'(psel), 64'd1);
      chk("wait_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("wait_paddr", 64'(paddr), 64'(v.addr));
      chk("wait_pwdata", 64'(pwdata), 64'(v.wdata));
      chk("wait_rsp_valid", 64'(rsp_valid), 64'd0);
    end

    @(negedge pclk);
    pready  = 1'b1;
    prdata  = v.rdata;
    pslverr = v.slverr;
    #1;
    chk("done_penable", 64'(penable), 64'd1);
    chk("done_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("done_paddr", 64'(paddr), 64'(v.addr));

    @(negedge pclk);
    pready  = 1'b0;
    prdata  = 32'hBAD0_BAD0;
    pslverr = 1'b0;
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_err", 64'(rsp_err), 64'(v.exp_err));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
    chk("post_psel", 64'(psel), 64'd0);
    chk("post_penable", 64'(penable), 64'd0);
  endtask

  initial begin
    vecs[0] = '{wr:1'b1, addr:32'h0000_0008, wdata:32'hDEAD_BEEF, strb:4'hF, prot:3'd0, waits:0,
                rdata:32'h0, slverr:1'b0, exp_err:1'b0, exp_rdata:32'h0, exp_strb:4'hF};
    vecs[1] = '{wr:1'b0, addr:32'h0000_0008, wdata:32'h0, strb:4'hF, prot:3'd0, waits:2,
                rdata:32'hDEAD_BEEF, slverr:1'b0, exp_err:1'b0, exp_rdata:32'hDEAD_BEEF, exp_strb:4'h0};
    vecs[2] = '{wr:1'b1, addr:32'h0000_0003, wdata:32'h1234_5678, strb:4'h5, prot:3'd3, waits:0,
                rdata:32'h7777_7777, slverr:1'b1, exp_err:1'b1, exp_rdata:32'h0, exp_strb:4'h5};
    vecs[3] = '{wr:1'b0, addr:32'h0000_1000, wdata:32'hFFFF_FFFF, strb:4'hA, prot:3'd7, waits:1,
                rdata:32'hA5A5_5A5A, slverr:1'b1, exp_err:1'b1, exp_rdata:32'hA5A5_5A5A, exp_strb:4'h0};
    vecs[4] = '{wr:1'b1, addr:32'hFFFF_FFFC, wdata:32'h0F0F_F0F0, strb:4'h9, prot:3'd2, waits:3,
                rdata:32'h3333_3333, slverr:1'b0, exp_err:1'b0, exp_rdata:32'h0, exp_strb:4'h9};

    preset    = 1'b1;
    cmd_valid = 1'b0;
    drive_cmd(1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
    prdata    = 32'h0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    // Reset state
    repeat (2) @(negedge pclk);
    cmd_valid = 1'b1;
    drive_cmd(1'b1, 32'h1111_1111, 32'h2222_2222, 4'hF, 3'h7);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pstrb", 64'(pstrb), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    @(negedge pclk);
    cmd_valid = 1'b0;
    preset    = 1'b0;
    #1;
    chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rel_psel", 64'(psel), 64'd0);

    for (int i = 0; i < 5; i++) do_xfer(vecs[i]);

    // Back-to-back with cmd_valid held
    @(negedge pclk);
    cmd_valid = 1'b1;
    drive_cmd(1'b1, 32'h0000_0040, 32'h1111_1111, 4'hF, 3'd1);
    #1;
    chk("b2b_ready0", 64'(cmd_ready), 64'd1);
    @(negedge pclk);
    drive_cmd(1'b0, 32'h0000_0044, 32'h0, 4'hF, 3'd0);
    #1;
    chk("b2b_setup1_psel", 64'(psel), 64'd1);
    chk("b2b_setup1_penable", 64'(penable), 64'd0);
    chk("b2b_setup1_paddr", 64'(paddr), 64'h40);
    @(negedge pclk);
    pready = 1'b1;
    prdata = 32'hBAD0_BAD0;
    #1;
    chk("b2b_access1_penable", 64'(penable), 64'd1);
    chk("b2b_access1_ready", 64'(cmd_ready), 64'd1);
    @(negedge pclk);
    cmd_valid = 1'b0;
    pready    = 1'b0;
    #1;
    chk("b2b_rsp1_valid", 64'(rsp_valid), 64'd1);
    chk("b2b_rsp1_rdata", 64'(rsp_rdata), 64'd0);
    chk("b2b_setup2_psel", 64'(psel), 64'd1);
    chk("b2b_setup2_penable", 64'(penable), 64'd0);
    chk("b2b_setup2_paddr", 64'(paddr), 64'h44);
    chk("b2b_setup2_pwrite", 64'(pwrite), 64'd0);
    chk("b2b_setup2_pstrb", 64'(pstrb), 64'd0);
    @(negedge pclk);
    pready = 1'b1;
    prdata = 32'hCAFE_F00D;
    #1;
    chk("b2b_access2_psel", 64'(psel), 64'd1);
    chk("b2b_access2_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge pclk);
    pready = 1'b0;
    prdata = 32'hBAD0_BAD0;
    #1;
    chk("b2b_rsp2_valid", 64'(rsp_valid), 64'd1);
    chk("b2b_rsp2_rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
    chk("b2b_rsp2_err", 64'(rsp_err), 64'd0);
    chk("b2b_end_psel", 64'(psel), 64'd0);

    // Reset asserted during ACCESS
    @(negedge pclk);
    cmd_valid = 1'b1;
    drive_cmd(1'b1, 32'h0000_0080, 32'h9999_9999, 4'h3, 3'd4);
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    #1;
    chk("rstx_access_penable", 64'(penable), 64'd1);
    #1;
    preset = 1'b1;
    #1;
    chk("rstx_psel", 64'(psel), 64'd0);
    chk("rstx_penable", 64'(penable), 64'd0);
    chk("rstx_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rstx_paddr", 64'(paddr), 64'd0);
    chk("rstx_pwrite", 64'(pwrite), 64'd0);
    @(negedge pclk);
    pready = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    #1;
    chk("rstx_rel_ready", 64'(cmd_ready), 64'd1);
    chk("rstx_rel_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge pclk);
    pready = 1'b0;
    #1;
    chk("rstx_after_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstx_after_psel", 64'(psel), 64'd0);

`ifdef APB_REQ_TIMEOUT_EN
    // Completer never ready: abort after TIMEOUT=4 ACCESS cycles
    @(negedge pclk);
    cmd_valid = 1'b1;
    drive_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'd0);
    @(negedge pclk);
    cmd_valid = 1'b0;
    for (int unsigned w = 0; w < 4; w++) begin
      @(negedge pclk);
      #1;
      chk("tmo_wait_penable", 64'(penable), 64'd1);
      chk("tmo_wait_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    @(negedge pclk);
    #1;
    chk("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("tmo_rsp_err", 64'(rsp_err), 64'd1);
    chk("tmo_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("tmo_psel", 64'(psel), 64'd0);
    chk("tmo_cmd_ready", 64'(cmd_ready), 64'd1);
`else
    // Far more wait states than TIMEOUT: no abort without the timeout build
    begin
      vec_t lw;
      lw = '{wr:1'b0, addr:32'h0000_0020, wdata:32'h0, strb:4'hF, prot:3'd5, waits:20,
             rdata:32'h0BAD_CAFE, slverr:1'b0, exp_err:1'b0, exp_rdata:32'h0BAD_CAFE, exp_strb:4'h0};
      do_xfer(lw);
    end
`endif

    @(negedge pclk);
    #1;
    chk("final_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("final_cmd_ready", 64'(cmd_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
